// File: rtl/rat_ckpt_multi.sv
// Register alias table for the out-of-order core.
// Each architectural register maps either to the register file or to a ROB tag.
// The table takes one rename and N_CMT tag-checked commit releases per cycle,
// and a flush discards every speculative mapping.
module rat_ckpt_multi #(
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned AREG_W    = 5,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned N_CMT     = 2,
    parameter bit          ZERO_HW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    rn_valid,
    input  logic [AREG_W-1:0]       rn_dest,
    input  logic [TAG_W-1:0]        rn_tag,
    input  logic [AREG_W-1:0]       rs_in,
    input  logic [AREG_W-1:0]       rt_in,
    input  logic [N_CMT-1:0]        cm_valid,
    input  logic [N_CMT*AREG_W-1:0] cm_areg,
    input  logic [N_CMT*TAG_W-1:0]  cm_tag,
    output logic [TAG_W-1:0]        rs_tag,
    output logic [TAG_W-1:0]        rt_tag,
    output logic                    rs_alloc,
    output logic                    rt_alloc,
    output logic [AREG_W:0]         alloc_count
);

    localparam logic [AREG_W:0] CNT_ONE = {{AREG_W{1'b0}}, 1'b1};

    logic [TAG_W-1:0]     tag_q [NUM_AREGS];
    logic [TAG_W-1:0]     tag_d [NUM_AREGS];
    logic [NUM_AREGS-1:0] alloc_q, alloc_d;
    logic [NUM_AREGS-1:0] alloc_cm;
    logic [AREG_W:0]      cnt_q, cnt_d;
    logic [AREG_W:0]      rel_cnt;
    logic                 rn_ok;
    logic [TAG_W-1:0]     rs_tag_q, rs_tag_d, rt_tag_q, rt_tag_d;
    logic                 rs_alloc_q, rs_alloc_d, rt_alloc_q, rt_alloc_d;

    function automatic logic in_range(input logic [AREG_W-1:0] a);
        return 32'(a) < NUM_AREGS;
    endfunction

    // Index that can ever hold a mapping: in range and not the hardwired zero register.
    function automatic logic mappable(input logic [AREG_W-1:0] a);
        return in_range(a) && !(ZERO_HW && (a == '0));
    endfunction

    // Commit releases in port order; a port only releases while the bit is still set,
    // so duplicate commits of one mapping count a single release.
    always_comb begin
        alloc_cm = alloc_q;
        rel_cnt  = '0;
        for (int unsigned i = 0; i < N_CMT; i++) begin
            if (cm_valid[i] && in_range(cm_areg[i*AREG_W +: AREG_W])
                && alloc_cm[cm_areg[i*AREG_W +: AREG_W]]
                && (tag_q[cm_areg[i*AREG_W +: AREG_W]] == cm_tag[i*TAG_W +: TAG_W])) begin
                alloc_cm[cm_areg[i*AREG_W +: AREG_W]] = 1'b0;
                rel_cnt = rel_cnt + CNT_ONE;
            end
        end
    end

    // Source lookups see the post-release table, never this cycle's rename.
    always_comb begin
        rs_alloc_d = !flush && mappable(rs_in) && alloc_cm[rs_in];
        rt_alloc_d = !flush && mappable(rt_in) && alloc_cm[rt_in];
        rs_tag_d   = rs_alloc_d ? tag_q[rs_in] : '0;
        rt_tag_d   = rt_alloc_d ? tag_q[rt_in] : '0;
    end

    // Rename on top of releases, flush on top of both; count moves incrementally.
    always_comb begin
        rn_ok   = rn_valid && mappable(rn_dest);
        alloc_d = alloc_cm;
        tag_d   = tag_q;
        cnt_d   = cnt_q - rel_cnt;
        if (rn_ok) begin
            alloc_d[rn_dest] = 1'b1;
            tag_d[rn_dest]   = rn_tag;
            if (!alloc_cm[rn_dest]) begin
                cnt_d = cnt_d + CNT_ONE;
            end
        end
        if (flush) begin
            alloc_d = '0;
            tag_d   = tag_q;
            cnt_d   = '0;
        end
    end

    // State and registered lookup results, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q      <= '{default: '0};
            alloc_q    <= '0;
            cnt_q      <= '0;
            rs_tag_q   <= '0;
            rt_tag_q   <= '0;
            rs_alloc_q <= 1'b0;
            rt_alloc_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            alloc_q    <= alloc_d;
            cnt_q      <= cnt_d;
            rs_tag_q   <= rs_tag_d;
            rt_tag_q   <= rt_tag_d;
            rs_alloc_q <= rs_alloc_d;
            rt_alloc_q <= rt_alloc_d;
        end
    end

    assign rs_tag      = rs_tag_q;
    assign rt_tag      = rt_tag_q;
    assign rs_alloc    = rs_alloc_q;
    assign rt_alloc    = rt_alloc_q;
    assign alloc_count = cnt_q;

endmodule

// File: tb/tb_rat_ckpt_multi.sv
// Scoreboard bench for rat_ckpt_multi: directed scenarios followed by random traffic,
// all checked against a rule-level model of the alias table.
module tb_rat_ckpt_multi;

    logic       clk = 1'b0;
    logic       rst, flush, rn_valid;
    logic [4:0] rn_dest, rn_tag, rs_in, rt_in;
    logic [1:0] cm_valid;
    logic [9:0] cm_areg, cm_tag;
    logic [4:0] rs_tag, rt_tag;
    logic       rs_alloc, rt_alloc;
    logic [5:0] alloc_count;

    typedef struct {
        logic [4:0] rs_tag;
        logic       rs_alloc;
        logic [4:0] rt_tag;
        logic       rt_alloc;
        logic [5:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [4:0] m_tag   [32];
    logic       m_alloc [32];

    always #5 clk = ~clk;

    rat_ckpt_multi #(
        .NUM_AREGS(32), .AREG_W(5), .TAG_W(5), .N_CMT(2), .ZERO_HW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rn_valid(rn_valid), .rn_dest(rn_dest), .rn_tag(rn_tag),
        .rs_in(rs_in), .rt_in(rt_in),
        .cm_valid(cm_valid), .cm_areg(cm_areg), .cm_tag(cm_tag),
        .rs_tag(rs_tag), .rt_tag(rt_tag), .rs_alloc(rs_alloc), .rt_alloc(rt_alloc),
        .alloc_count(alloc_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rs_alloc", int'(rs_alloc), int'(e.rs_alloc));
                chk("rs_tag", int'(rs_tag), int'(e.rs_tag));
                chk("rt_alloc", int'(rt_alloc), int'(e.rt_alloc));
                chk("rt_tag", int'(rt_tag), int'(e.rt_tag));
                chk("alloc_count", int'(alloc_count), int'(e.cnt));
            end
        end
    end

    task automatic idle();
        flush = 0; rn_valid = 0; rn_dest = 0; rn_tag = 0;
        cm_valid = 0; cm_areg = 0; cm_tag = 0;
    endtask

    task automatic set_cm(input int p, input int a, input int t);
        cm_valid[p]        = 1'b1;
        cm_areg[p*5 +: 5]  = 5'(a);
        cm_tag[p*5 +: 5]   = 5'(t);
    endtask

    task automatic rename(input int d, input int t);
        rn_valid = 1'b1; rn_dest = 5'(d); rn_tag = 5'(t);
    endtask

    // Apply the table rules to the current inputs, push the expected outputs, advance a cycle.
    task automatic cycle();
        exp_t       e;
        logic [4:0] a;
        int         pc;
        e = '{default: '0};
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin m_tag[i] = 0; m_alloc[i] = 0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = cm_areg[p*5 +: 5];
                if (cm_valid[p] && m_alloc[a] && m_tag[a] == cm_tag[p*5 +: 5]) m_alloc[a] = 0;
            end
            e.rs_alloc = !flush && rs_in != 0 && m_alloc[rs_in];
            e.rt_alloc = !flush && rt_in != 0 && m_alloc[rt_in];
            e.rs_tag   = e.rs_alloc ? m_tag[rs_in] : 5'd0;
            e.rt_tag   = e.rt_alloc ? m_tag[rt_in] : 5'd0;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_alloc[i] = 0;
            end else if (rn_valid && rn_dest != 0) begin
                m_alloc[rn_dest] = 1; m_tag[rn_dest] = rn_tag;
            end
        end
        pc = 0;
        for (int i = 0; i < 32; i++) pc += int'(m_alloc[i]);
        e.cnt = 6'(pc);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_areg();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a;
        idle(); rst = 0; rs_in = 5; rt_in = 31;
        @(negedge clk);
        cycle(); cycle();
        rst = 1;
        cycle();                                          // lookups after reset read 0

        rename(7, 12); cycle(); idle();
        rs_in = 7; cycle();                               // r7 -> 12, count 1
        set_cm(0, 7, 12); cycle(); idle();                // released, lookup sees it
        cycle();

        rename(3, 4); cycle();
        rename(3, 9); cycle(); idle();
        set_cm(0, 3, 4); rs_in = 3; cycle(); idle();      // stale commit ignored
        set_cm(0, 3, 9); rename(3, 15); rs_in = 3; cycle(); idle();
        cycle();                                          // new mapping 15 remains

        flush = 1; cycle(); idle();
        rename(1, 2); cycle();
        rename(2, 3); cycle(); idle();
        set_cm(0, 1, 2); set_cm(1, 2, 3); rs_in = 1; rt_in = 2; cycle(); idle();
        rename(0, 6); rs_in = 0; cycle(); idle();
        cycle();                                          // r0 stays unallocated

        for (int i = 10; i < 20; i++) begin rename(i, i); cycle(); end
        idle(); rs_in = 12; rt_in = 19;
        flush = 1; rename(20, 1); cycle(); idle();
        rs_in = 20; cycle();                              // dropped rename
        rename(5, 5); cycle(); rename(6, 6); cycle(); idle();
        set_cm(0, 5, 5); set_cm(1, 6, 6); rs_in = 5; rt_in = 6; rst = 0; cycle();
        rst = 1; idle(); cycle();

        for (int n = 0; n < 2000; n++) begin
            rst      = ($urandom_range(0, 79) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            rn_valid = ($urandom_range(0, 3) != 0);
            rn_dest  = pick_areg();
            rn_tag   = 5'($urandom);
            rs_in    = pick_areg();
            rt_in    = pick_areg();
            cm_valid = 0; cm_areg = 0; cm_tag = 0;
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = (p == 1 && $urandom_range(0, 3) == 0) ? cm_areg[4:0] : pick_areg();
                    set_cm(p, int'(a), ($urandom_range(0, 3) != 0) ? int'(m_tag[a]) : int'($urandom_range(0, 31)));
                end
            end
            cycle();
        end

        idle();
        #5;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
